// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among N_REQ requesters, 1-cycle tagged response.
// Optional per-requester grant/stall counters enabled by defining BRAM_ARB_PERF_EN.
module bram_read_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64
`ifdef BRAM_ARB_PERF_EN
  ,parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [ADDR_WIDTH-1:0]       mem_r_addr,
  output logic                        mem_r_valid,
  input  logic [DATA_WIDTH-1:0]       mem_r_data,
  output logic                        busy
`ifdef BRAM_ARB_PERF_EN
  ,input  logic                       cnt_clear
  ,output logic [N_REQ*CNT_WIDTH-1:0] grant_cnt
  ,output logic [N_REQ*CNT_WIDTH-1:0] stall_cnt
`endif
);

  localparam int unsigned      PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0]   N_REQ_P  = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0] r_rr_ptr;
  logic [N_REQ-1:0] r_rsp_id;

  logic [N_REQ-1:0] w_grant;
  logic [PTR_W-1:0] w_gidx;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W:0]   w_sum;
  logic             w_found;
  logic [ADDR_WIDTH-1:0] w_addr;

  // Search from r_rr_ptr upward with wrap; first requesting index wins.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_idx   = '0;
    w_sum   = '0;
    w_found = 1'b0;
    w_addr  = '0;
    if (!rst && enable) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
        if (w_sum >= N_REQ_P) w_sum = w_sum - N_REQ_P;
        w_idx = w_sum[PTR_W-1:0];
        if (!w_found && req_valid[w_idx]) begin
          w_found = 1'b1;
          w_gidx  = w_idx;
        end
      end
    end
    if (w_found) w_grant[w_gidx] = 1'b1;
    // Mux only the granted slice so X on idle requesters never reaches the BRAM.
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (w_grant[j]) w_addr = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign req_ready   = w_grant;
  assign mem_r_valid = w_found;
  assign mem_r_addr  = w_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_rsp_id <= '0;
    end else begin
      r_rsp_id <= w_grant;
      if (w_found) r_rr_ptr <= (w_gidx == LAST_IDX) ? '0 : w_gidx + PTR_W'(1);
    end
  end

  assign rsp_valid = r_rsp_id;
  assign rsp_data  = mem_r_data;
  assign busy      = |r_rsp_id;

`ifdef BRAM_ARB_PERF_EN
  // Saturating counters; clear has priority over increment.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf
    logic [CNT_WIDTH-1:0] r_grant_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
      if (rst || cnt_clear) begin
        r_grant_cnt <= '0;
        r_stall_cnt <= '0;
      end else begin
        if (w_grant[gi] && (r_grant_cnt != '1))
          r_grant_cnt <= r_grant_cnt + CNT_WIDTH'(1);
        if (req_valid[gi] && !w_grant[gi] && (r_stall_cnt != '1))
          r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
    end

    assign grant_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_grant_cnt;
    assign stall_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_stall_cnt;
  end
`endif

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed self-checking bench for bram_read_arbiter with a 1-cycle BRAM model.
module tb_bram_read_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   mem_r_addr;
  logic            mem_r_valid;
  logic [DW-1:0]   mem_r_data;
  logic            busy;
`ifdef BRAM_ARB_PERF_EN
  logic            cnt_clear;
  logic [N*4-1:0]  grant_cnt;
  logic [N*4-1:0]  stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [AW-1:0] a [N];

  bram_read_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
`ifdef BRAM_ARB_PERF_EN
    ,.CNT_WIDTH(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_r_addr(mem_r_addr), .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data),
    .busy(busy)
`ifdef BRAM_ARB_PERF_EN
    ,.cnt_clear(cnt_clear), .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] addr);
    if (addr == 9'h1A5) return 64'hDEAD_BEEF_0000_0001;
    return {32'hC0DE_0000, 23'h0, addr};
  endfunction

  always_ff @(posedge clk) begin
    if (mem_r_valid) mem_r_data <= bram_word(mem_r_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp1h;
    a[0] = 9'h100; a[1] = 9'h0F1; a[2] = 9'h1A5; a[3] = 9'h033;
    req_addr   = {a[3], a[2], a[1], a[0]};
    mem_r_data = '0;
    rst = 1'b1; enable = 1'b1; req_valid = 4'b1111;
`ifdef BRAM_ARB_PERF_EN
    cnt_clear = 1'b0;
`endif
    #1;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_mvalid", mem_r_valid, 1'b0);
    check("rst_maddr", mem_r_addr, 9'h000);
    tick(); tick();
    check("rst_rsp", rsp_valid, 4'b0000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0; req_valid = 4'b0000; #1;
    check("idle_ready", req_ready, 4'b0000);
    check("idle_mvalid", mem_r_valid, 1'b0);

    // Single read from requester 2
    req_valid = 4'b0100; #1;
    check("r2_ready", req_ready, 4'b0100);
    check("r2_maddr", mem_r_addr, 9'h1A5);
    check("r2_mvalid", mem_r_valid, 1'b1);
    tick();
    req_valid = 4'b0000; #1;
    check("r2_rsp", rsp_valid, 4'b0100);
    check("r2_data", rsp_data, 64'hDEAD_BEEF_0000_0001);
    check("r2_busy", busy, 1'b1);
    tick();
    check("r2_rsp_done", rsp_valid, 4'b0000);
    check("r2_busy_done", busy, 1'b0);

    // All requesting from reset: strict rotation
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp1h = 4'b0001 << (c % 4);
      check($sformatf("rot_ready%0d", c), req_ready, exp1h);
      check($sformatf("rot_maddr%0d", c), mem_r_addr, a[c % 4]);
      if (c > 0) begin
        exp1h = 4'b0001 << ((c - 1) % 4);
        check($sformatf("rot_rsp%0d", c), rsp_valid, exp1h);
        check($sformatf("rot_data%0d", c), rsp_data, bram_word(a[(c - 1) % 4]));
      end
      tick();
    end
    req_valid = 4'b0000; #1;
    check("rot_rsp_last", rsp_valid, 4'b1000);
    check("rot_data_last", rsp_data, bram_word(a[3]));
    tick();

    // Wrap-around: grant 2 sets pointer to 3, then 3,0,3
    req_valid = 4'b0100; #1;
    check("wrap_pre", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1001; #1;
    check("wrap_g3", req_ready, 4'b1000);
    tick();
    check("wrap_g0", req_ready, 4'b0001);
    tick();
    check("wrap_g3b", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0000; tick();

    // Enable dropped with a response in flight
    req_valid = 4'b0010; #1;
    check("en_g1", req_ready, 4'b0010);
    tick();
    enable = 1'b0; req_valid = 4'b1111; #1;
    check("en_rsp", rsp_valid, 4'b0010);
    check("en_busy", busy, 1'b1);
    check("en_ready_off", req_ready, 4'b0000);
    check("en_mvalid_off", mem_r_valid, 1'b0);
    tick();
    check("en_rsp_gone", rsp_valid, 4'b0000);
    check("en_ready_off2", req_ready, 4'b0000);
    enable = 1'b1; #1;
    check("en_resume", req_ready, 4'b0100);
    tick();

    // Reset mid-operation drops the in-flight response and rewinds the pointer
    check("mid_pre", req_ready, 4'b1000);
    rst = 1'b1; tick();
    check("mid_rsp_drop", rsp_valid, 4'b0000);
    check("mid_busy", busy, 1'b0);
    rst = 1'b0; #1;
    check("mid_ptr0", req_ready, 4'b0001);
    tick();

    // Lone requester granted every cycle
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("solo_ready%0d", c), req_ready, 4'b0001);
      check($sformatf("solo_rsp%0d", c), rsp_valid, 4'b0001);
      tick();
    end

    // X on an idle requester's address must not leak
    req_addr[0 +: AW] = 'x;
    req_valid = 4'b0010; #1;
    check("xaddr_maddr", mem_r_addr, 9'h0F1);
    req_addr = {a[3], a[2], a[1], a[0]};
    req_valid = 4'b0000; tick(); tick();

`ifdef BRAM_ARB_PERF_EN
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) tick();
    check("perf_gsat", grant_cnt[3:0], 4'hF);
    req_valid = 4'b0011;
    for (int c = 0; c < 6; c++) tick();
    check("perf_stall1", stall_cnt[7:4], 4'd3);
    check("perf_grant1", grant_cnt[7:4], 4'd3);
    check("perf_gsat_hold", grant_cnt[3:0], 4'hF);
    cnt_clear = 1'b1; tick(); cnt_clear = 1'b0;
    check("perf_clr_g", grant_cnt, 16'h0000);
    check("perf_clr_s", stall_cnt, 16'h0000);
    req_valid = 4'b0000; tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
